// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Contents: controller state encoding and default operand width.
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } sa_state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder used as the single arithmetic cell
// of the serial adder.
// Ports: a, b, cin -> sum_c, cout_c (both combinational).
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    always_comb begin
        sum_c  = a ^ b ^ cin;
        cout_c = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, through a single full-adder cell and a registered carry.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin an addition (sampled in IDLE or DONE)
//   a, b, cin     - operands, captured on the accepting edge
//   busy          - high while bits are being processed
//   done          - one-cycle pulse when sum/cout are valid
//   sum, cout     - result, held until the next accepted start
//   ovf           - (SERIAL_ADDER_OVF_EN) two's-complement overflow, held with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;
    logic last_bit;

    // The single arithmetic cell, fed from the operand LSBs and the carry.
    fa_bit u_fa (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .cin    (carry_q),
        .sum_c  (fa_sum),
        .cout_c (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ADD;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                // Sum bits enter at the MSB so bit i lands at position i
                // after WIDTH shifts.
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (last_bit) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this cycle.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, random
// additions against an arithmetic reference, and hand-written sequences
// for back-to-back starts, ignored mid-add starts and mid-add reset.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int   n_tests;
    int   n_fail;
    logic model_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [9:0] model_add(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
        int unsigned u;
        int          s;
        logic        v;
        u = int'(ma) + int'(mb) + int'(mc);
        s = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        v = (s > 127) || (s < -128);
        return {v, 1'(u >> 8), 8'(u)};
    endfunction

    // From a negedge while busy, step until done; lat counts the negedges taken.
    task automatic wait_done(input string name, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 3 * int'(W)) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, "/done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_b, input logic tc,
                           input logic [7:0] es, input logic ec, input logic eo, input string name);
        int lat;
        bit busy_ok;
        @(negedge clk);
        a = ta; b = tb_b; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Operands scrambled after capture must not matter.
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check({name, "/sum_cleared"}, 64'(sum), 64'(0));
        check({name, "/cout_held"}, 64'(cout), 64'(model_cout));
        wait_done(name, lat, busy_ok);
        check({name, "/latency"}, 64'(lat), 64'(W));
        check({name, "/busy_during"}, 64'(busy_ok), 64'(1));
        check({name, "/busy_at_done"}, 64'(busy), 64'(0));
        check({name, "/sum"}, 64'(sum), 64'(es));
        check({name, "/cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({name, "/ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("note: ovf expectation undefined for %s", name);
`endif
        model_cout = ec;
        @(negedge clk);
        check({name, "/done_pulse"}, 64'(done), 64'(0));
        check({name, "/sum_hold"}, 64'({cout, sum}), 64'({ec, es}));
    endtask

    initial begin
        vec_t       vecs[5];
        logic [9:0] m;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         lat;
        int         lat2;
        int         dcount;
        bit         busy_ok;

        n_tests    = 0;
        n_fail     = 0;
        model_cout = 1'b0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset/busy", 64'(busy), 64'(0));
        check("reset/done", 64'(done), 64'(0));
        check("reset/sum", 64'(sum), 64'(0));
        check("reset/cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("reset/ovf", 64'(ovf), 64'(0));
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle/no_busy", 64'(busy), 64'(0));

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                    vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Random additions against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            m  = model_add(ra, rb, rc);
            run_add(ra, rb, rc, m[7:0], m[8], m[9], $sformatf("rnd%0d", i));
        end

        // start and operand changes inside ADD are ignored.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart", lat, busy_ok);
        check("midstart/latency", 64'(lat + 3), 64'(W));
        check("midstart/sum", 64'(sum), 64'(8'h96));
        check("midstart/cout", 64'(cout), 64'(0));
        @(negedge clk);
        check("midstart/idle", 64'({busy, done}), 64'(0));
        model_cout = 1'b0;

        // Back-to-back: start held through DONE picks up the new operands.
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0;
        wait_done("b2b_first", lat, busy_ok);
        check("b2b_first/latency", 64'(lat), 64'(W));
        check("b2b_first/sum", 64'(sum), 64'(8'h96));
        @(negedge clk);
        start = 1'b0;
        check("b2b/accepted_busy", 64'(busy), 64'(1));
        check("b2b/sum_cleared", 64'(sum), 64'(0));
        wait_done("b2b_second", lat2, busy_ok);
        check("b2b/done_spacing", 64'(lat2 + 1), 64'(W + 1));
        check("b2b_second/sum", 64'(sum), 64'(8'h30));
        check("b2b_second/cout", 64'(cout), 64'(0));
        @(negedge clk);
        check("b2b/done_pulse", 64'(done), 64'(0));
        model_cout = 1'b0;

        // Leave cout=1 so the reset clearing it is observable.
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "pre_reset");

        // Reset at E4 of an addition discards it.
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset/busy", 64'(busy), 64'(0));
        check("midreset/done", 64'(done), 64'(0));
        check("midreset/sum", 64'(sum), 64'(0));
        check("midreset/cout", 64'(cout), 64'(0));
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        check("midreset/no_activity", 64'(dcount), 64'(0));
        model_cout = 1'b0;

        // Recovery after reset.
        run_add(8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
